// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the E->M pipeline stage register: state encoding,
// default payload width and the storage control bundle.
package pipe_skid_reg_pkg;

    // Default payload: PC, Instr, ALUresult, rt, HILOout (5 x 32 bits).
    localparam int unsigned PIPE_DEFAULT_WIDTH = 160;

    // State register width; the encoding doubles as the live-entry count.
    localparam int unsigned PIPE_STATE_W = 2;

    localparam logic [PIPE_STATE_W-1:0] ST_EMPTY   = 2'd0;
    localparam logic [PIPE_STATE_W-1:0] ST_FULL    = 2'd1;
    localparam logic [PIPE_STATE_W-1:0] ST_SKIDDED = 2'd2;

    // Per-cycle commands to the main and skid storage registers.
    typedef struct packed {
        logic main_load;       // capture new payload into the main register
        logic main_from_skid;  // main register source is the skid entry
        logic main_clr;        // main register returns to BUBBLE
        logic skid_load;       // park the incoming payload in the skid entry
        logic skid_clr;        // skid entry returns to BUBBLE
    } pipe_ctrl_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload storage register with load enable and synchronous clear-to-BUBBLE.
// Clear wins over load so a kill and a capture in the same cycle leave BUBBLE.
module pipe_data_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned      WIDTH  = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    // Hold, clear to BUBBLE, or capture the new payload.
    always_ff @(posedge clk) begin
        if (clr) begin
            data_q <= BUBBLE;
        end else if (load) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with an optional two-entry skid buffer.
// With SKID=1 in_ready depends only on registered state, breaking the
// out_ready -> in_ready path; with SKID=0 it is a single register whose
// in_ready follows the downstream consume. out_data is always registered.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned      WIDTH  = PIPE_DEFAULT_WIDTH,
    parameter int unsigned      SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [PIPE_STATE_W-1:0] state_q;
    logic [PIPE_STATE_W-1:0] state_d;
    pipe_ctrl_t              ctrl_c;

    logic             accept_c;
    logic             consume_c;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign accept_c  = in_valid && in_ready;
    assign consume_c = out_valid && out_ready;

    // State register; reset priority is resolved in the next-state logic.
    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Next state and storage commands: reset, then flush, then handshakes.
    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;

        if (reset || flush) begin
            state_d         = ST_EMPTY;
            ctrl_c.main_clr = 1'b1;
            ctrl_c.skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d          = ST_FULL;
                        ctrl_c.main_load = 1'b1;
                    end
                end

                ST_FULL: begin
                    if (accept_c && consume_c) begin
                        ctrl_c.main_load = 1'b1;
                    end else if (consume_c) begin
                        state_d         = ST_EMPTY;
                        ctrl_c.main_clr = 1'b1;
                    end else if (accept_c && (SKID != 0)) begin
                        state_d          = ST_SKIDDED;
                        ctrl_c.skid_load = 1'b1;
                    end
                end

                ST_SKIDDED: begin
                    // Older main entry leaves first; skid entry moves up.
                    if (consume_c) begin
                        state_d               = ST_FULL;
                        ctrl_c.main_load      = 1'b1;
                        ctrl_c.main_from_skid = 1'b1;
                        ctrl_c.skid_clr       = 1'b1;
                    end
                end

                default: begin
                    state_d         = ST_EMPTY;
                    ctrl_c.main_clr = 1'b1;
                    ctrl_c.skid_clr = 1'b1;
                end
            endcase
        end
    end

    // Main register source: the upstream payload or the parked skid entry.
    always_comb begin
        main_d = in_data;
        if (ctrl_c.main_from_skid) begin
            main_d = skid_q;
        end
    end

    pipe_data_reg #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_main_reg (
        .clk  (clk),
        .clr  (ctrl_c.main_clr),
        .load (ctrl_c.main_load),
        .d    (main_d),
        .q    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_data_reg #(
                .WIDTH  (WIDTH),
                .BUBBLE (BUBBLE)
            ) u_skid_reg (
                .clk  (clk),
                .clr  (ctrl_c.skid_clr),
                .load (ctrl_c.skid_load),
                .d    (in_data),
                .q    (skid_q)
            );

            // Ready only from registered state: no out_ready feed-through.
            assign in_ready = !reset && (state_q != ST_SKIDDED);
        end else begin : g_no_skid
            logic unused_skid_ctrl;

            assign skid_q           = BUBBLE;
            assign unused_skid_ctrl = ctrl_c.skid_load | ctrl_c.skid_clr;

            // Single entry: refill only when empty or draining this cycle.
            assign in_ready = !reset && (!out_valid || out_ready);
        end
    endgenerate

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: one skid instance (SKID=1) and one
// single-register instance (SKID=0), checked against a scoreboard queue.
module tb_pipe_skid_reg;

    localparam int unsigned      W   = 160;
    localparam logic [W-1:0]     BUB = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sb_q[$];

    // SKID=1 instance signals
    logic         a_reset, a_flush, a_in_valid, a_out_ready;
    logic [W-1:0] a_in_data;
    logic         a_in_ready, a_out_valid;
    logic [W-1:0] a_out_data;
    logic [1:0]   a_occ;

    // SKID=0 instance signals
    logic         b_reset, b_flush, b_in_valid, b_out_ready;
    logic [W-1:0] b_in_data;
    logic         b_in_ready, b_out_valid;
    logic [W-1:0] b_out_data;
    logic [1:0]   b_occ;

    pipe_skid_reg #(.WIDTH(W), .SKID(1), .BUBBLE(BUB)) u_dut_skid (
        .clk       (clk),
        .reset     (a_reset),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    pipe_skid_reg #(.WIDTH(W), .SKID(0), .BUBBLE(BUB)) u_dut_reg (
        .clk       (clk),
        .reset     (b_reset),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        @(posedge clk); #1;
        a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        a_in_data = W'(32'hDEAD_BEEF);
        b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
        b_in_data = W'(32'hCAFE_F00D);
        #1;
        total++;
        if (a_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_a got=%b exp=0", a_in_ready); end
        total++;
        if (b_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_b got=%b exp=0", b_in_ready); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        total++;
        if (a_out_data !== BUB) begin bad++; $display("FAIL reset_out_data got=%h exp=%h", a_out_data, BUB); end
        total++;
        if (a_occ !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", a_occ); end
        total++;
        if (a_in_ready !== 1'b0) begin bad++; $display("FAIL reset_hold_in_ready got=%b exp=0", a_in_ready); end
        total++;
        if (b_occ !== 2'd0) begin bad++; $display("FAIL reset_occupancy_b got=%0d exp=0", b_occ); end
        a_reset = 1'b0; a_in_valid = 1'b0;
        b_reset = 1'b0; b_in_valid = 1'b0;
        #1;
        total++;
        if (a_in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready_a got=%b exp=1", a_in_ready); end
        total++;
        if (b_in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready_b got=%b exp=1", b_in_ready); end
        total++;
        if (a_out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] exp;
        sb_q.delete();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            a_out_ready = 1'b1;
            a_in_valid  = (c < 3);
            a_in_data   = W'(32'h3000 + 4 * c);
            #1;
            if (c >= 1 && c <= 3) begin
                total++;
                if (a_occ !== 2'd1) begin bad++; $display("FAIL stream_occ cyc=%0d got=%0d exp=1", c, a_occ); end
            end
            if (c == 4) begin
                total++;
                if (a_out_valid !== 1'b0 || a_out_data !== BUB) begin
                    bad++; $display("FAIL stream_empty got=%b/%h exp=0/%h", a_out_valid, a_out_data, BUB);
                end
            end
            if (a_out_valid && a_out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++; $display("FAIL stream_extra got=%h exp=none", a_out_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (a_out_data !== exp) begin bad++; $display("FAIL stream_data got=%h exp=%h", a_out_data, exp); end
                end
            end
            if (a_in_valid && a_in_ready) sb_q.push_back(a_in_data);
        end
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL stream_lost got=%0d exp=0", sb_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp;
        logic [W-1:0] val_a;
        logic [W-1:0] val_b;
        val_a = rand_word();
        val_b = rand_word();
        sb_q.delete();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            a_in_valid  = (c < 4);
            a_out_ready = (c >= 4);
            a_in_data   = (c == 0) ? val_a : (c == 1) ? val_b : rand_word();
            #1;
            case (c)
                1: begin
                    total++;
                    if (a_out_data !== val_a || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
                        bad++; $display("FAIL bp_load got=%h/%0d/%b exp=%h/1/1", a_out_data, a_occ, a_in_ready, val_a);
                    end
                end
                2, 3: begin
                    total++;
                    if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== val_a || a_out_valid !== 1'b1) begin
                        bad++; $display("FAIL bp_skidded cyc=%0d got=%0d/%b/%h exp=2/0/%h", c, a_occ, a_in_ready, a_out_data, val_a);
                    end
                end
                6: begin
                    total++;
                    if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin
                        bad++; $display("FAIL bp_drained got=%0d/%b exp=0/0", a_occ, a_out_valid);
                    end
                end
                default: ;
            endcase
            if (a_out_valid && a_out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra got=%h exp=none", a_out_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (a_out_data !== exp) begin bad++; $display("FAIL bp_order got=%h exp=%h", a_out_data, exp); end
                end
            end
            if (a_in_valid && a_in_ready) sb_q.push_back(a_in_data);
        end
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL bp_lost got=%0d exp=0", sb_q.size()); end
    endtask

    task automatic test_flush();
        logic [W-1:0] exp;
        sb_q.delete();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            a_flush     = (c == 2) || (c == 5);
            a_in_valid  = (c <= 2) || (c == 4) || (c == 5);
            a_out_ready = (c == 3) || (c >= 6);
            a_in_data   = (c == 2 || c == 5) ? W'(32'h0000_0C0C) : rand_word();
            #1;
            case (c)
                2: begin
                    total++;
                    if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin
                        bad++; $display("FAIL flush_pre_skid got=%0d/%b exp=2/0", a_occ, a_in_ready);
                    end
                end
                5: begin
                    total++;
                    if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
                        bad++; $display("FAIL flush_pre_full got=%0d/%b exp=1/1", a_occ, a_in_ready);
                    end
                end
                3, 6, 7: begin
                    total++;
                    if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== BUB) begin
                        bad++; $display("FAIL flush_killed cyc=%0d got=%0d/%b/%h exp=0/0/%h", c, a_occ, a_out_valid, a_out_data, BUB);
                    end
                end
                default: ;
            endcase
            if (a_flush) begin
                sb_q.delete();
            end else begin
                if (a_out_valid && a_out_ready) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++; $display("FAIL flush_leak got=%h exp=none", a_out_data);
                    end else begin
                        exp = sb_q.pop_front();
                        if (a_out_data !== exp) begin bad++; $display("FAIL flush_data got=%h exp=%h", a_out_data, exp); end
                    end
                end
                if (a_in_valid && a_in_ready) sb_q.push_back(a_in_data);
            end
        end
        a_flush = 1'b0;
        a_in_valid = 1'b0;
    endtask

    task automatic test_single_reg();
        logic [W-1:0] exp;
        logic [W-1:0] val_a;
        logic [W-1:0] val_b;
        val_a = rand_word();
        val_b = rand_word();
        sb_q.delete();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            b_in_valid  = (c <= 2);
            b_out_ready = (c == 0) || (c == 2) || (c >= 4);
            b_in_data   = (c == 0) ? val_a : val_b;
            #1;
            case (c)
                1: begin
                    total++;
                    if (b_in_ready !== 1'b0 || b_out_data !== val_a) begin
                        bad++; $display("FAIL reg_stalled got=%b/%h exp=0/%h", b_in_ready, b_out_data, val_a);
                    end
                end
                2: begin
                    total++;
                    if (b_in_ready !== 1'b1) begin bad++; $display("FAIL reg_replace_ready got=%b exp=1", b_in_ready); end
                end
                3: begin
                    total++;
                    if (b_out_valid !== 1'b1 || b_out_data !== val_b || b_occ !== 2'd1) begin
                        bad++; $display("FAIL reg_no_bubble got=%b/%h/%0d exp=1/%h/1", b_out_valid, b_out_data, b_occ, val_b);
                    end
                end
                5: begin
                    total++;
                    if (b_occ !== 2'd0 || b_out_data !== BUB) begin
                        bad++; $display("FAIL reg_drained got=%0d/%h exp=0/%h", b_occ, b_out_data, BUB);
                    end
                end
                default: ;
            endcase
            if (b_out_valid && b_out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++; $display("FAIL reg_extra got=%h exp=none", b_out_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (b_out_data !== exp) begin bad++; $display("FAIL reg_data got=%h exp=%h", b_out_data, exp); end
                end
            end
            if (b_in_valid && b_in_ready) sb_q.push_back(b_in_data);
        end
    endtask

    task automatic test_random_skid();
        logic [W-1:0] exp;
        int           n;
        sb_q.delete();
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            a_in_valid  = ($urandom_range(1) == 1);
            a_out_ready = ($urandom_range(1) == 1);
            a_flush     = ($urandom_range(127) == 0);
            a_in_data   = rand_word();
            #1;
            n = sb_q.size();
            total++;
            if (n > 2 || a_occ !== 2'(n) || a_out_valid !== (n != 0) || a_in_ready !== (n < 2)) begin
                bad++; $display("FAIL rnd_skid_state cyc=%0d got=%0d/%b/%b exp=%0d/%b/%b", c, a_occ, a_out_valid, a_in_ready, n, n != 0, n < 2);
            end
            if (a_flush) begin
                sb_q.delete();
            end else begin
                if (a_out_valid && a_out_ready) begin
                    total++;
                    if (n == 0) begin
                        bad++; $display("FAIL rnd_skid_extra cyc=%0d got=%h exp=none", c, a_out_data);
                    end else begin
                        exp = sb_q.pop_front();
                        if (a_out_data !== exp) begin bad++; $display("FAIL rnd_skid_data cyc=%0d got=%h exp=%h", c, a_out_data, exp); end
                    end
                end
                if (a_in_valid && a_in_ready) sb_q.push_back(a_in_data);
            end
        end
        a_flush = 1'b0;
        a_in_valid = 1'b0;
    endtask

    task automatic test_random_reg();
        logic [W-1:0] exp;
        int           n;
        sb_q.delete();
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            b_in_valid  = ($urandom_range(1) == 1);
            b_out_ready = ($urandom_range(1) == 1);
            b_flush     = ($urandom_range(127) == 0);
            b_in_data   = rand_word();
            #1;
            n = sb_q.size();
            total++;
            if (n > 1 || b_occ !== 2'(n) || b_out_valid !== (n != 0) || b_in_ready !== ((n == 0) || b_out_ready)) begin
                bad++; $display("FAIL rnd_reg_state cyc=%0d got=%0d/%b/%b exp=%0d/%b/%b", c, b_occ, b_out_valid, b_in_ready, n, n != 0, (n == 0) || b_out_ready);
            end
            if (b_flush) begin
                sb_q.delete();
            end else begin
                if (b_out_valid && b_out_ready) begin
                    total++;
                    if (n == 0) begin
                        bad++; $display("FAIL rnd_reg_extra cyc=%0d got=%h exp=none", c, b_out_data);
                    end else begin
                        exp = sb_q.pop_front();
                        if (b_out_data !== exp) begin bad++; $display("FAIL rnd_reg_data cyc=%0d got=%h exp=%h", c, b_out_data, exp); end
                    end
                end
                if (b_in_valid && b_in_ready) sb_q.push_back(b_in_data);
            end
        end
        b_flush = 1'b0;
        b_in_valid = 1'b0;
    endtask

    initial begin
        a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_single_reg();
        test_random_skid();
        test_random_reg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
